// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: EX/MEM destination scoreboard, registered forwarding
// selects, load-use bubble insertion and data-memory wait freeze.
// Optional build macro HAZARD_PERF_EN adds saturating stall counters
// (stall_cnt_lu / stall_cnt_mem); without it both ports read as zero.
module hazard_forward_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  branch_flush,
  input  logic                  dmem_busy,
  output logic                  rs1_exe_hazard,
  output logic                  rs1_mem_hazard,
  output logic                  rs2_exe_hazard,
  output logic                  rs2_mem_hazard,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  idex_bubble,
  output logic                  pipe_freeze,
  output logic [PERF_CNT_W-1:0] stall_cnt_lu,
  output logic [PERF_CNT_W-1:0] stall_cnt_mem
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Set for exactly one cycle after reset is released so that all control
  // outputs stay quiet in the reset cycle and the one following it.
  logic quiet_reg;

  // Scoreboard: destination of the instructions currently in EX and MEM.
  logic [REG_ADDR_W-1:0] ex_rd_reg;
  logic                  ex_wr_reg;
  logic                  ex_ld_reg;
  logic [REG_ADDR_W-1:0] mem_rd_reg;
  logic                  mem_wr_reg;

  // Registered forwarding selects for the instruction sitting in EX.
  logic rs1_exe_reg, rs1_mem_reg, rs2_exe_reg, rs2_mem_reg;

  logic active;
  logic rs1_ex_match, rs2_ex_match, rs1_mem_match, rs2_mem_match;
  logic freeze, lu_hazard, flush_bubble, bubble, take_id;

  // A source hits a tracked entry only when it is really read, the entry
  // really writes, and the register is not x0 (x0 never forwards).
  function automatic logic src_hit(input logic                  used,
                                   input logic [REG_ADDR_W-1:0] addr,
                                   input logic [REG_ADDR_W-1:0] rd,
                                   input logic                  wr);
    return used && wr && (rd != '0) && (addr == rd);
  endfunction

  assign active        = rst_n & ~quiet_reg;
  assign rs1_ex_match  = id_valid & src_hit(id_rs1_used, id_rs1_addr, ex_rd_reg,  ex_wr_reg);
  assign rs2_ex_match  = id_valid & src_hit(id_rs2_used, id_rs2_addr, ex_rd_reg,  ex_wr_reg);
  assign rs1_mem_match = id_valid & src_hit(id_rs1_used, id_rs1_addr, mem_rd_reg, mem_wr_reg);
  assign rs2_mem_match = id_valid & src_hit(id_rs2_used, id_rs2_addr, mem_rd_reg, mem_wr_reg);

  // Next-state and stall/bubble decode; dmem_busy outranks every other event.
  always_comb begin
    state_next   = state_reg;
    freeze       = 1'b0;
    lu_hazard    = 1'b0;
    flush_bubble = 1'b0;
    if (!active) begin
      state_next = RUN;
    end else if (dmem_busy) begin
      freeze     = 1'b1;
      state_next = MEM_WAIT;
    end else begin
      case (state_reg)
        RUN, MEM_WAIT: begin
          state_next = RUN;
          if (branch_flush) begin
            flush_bubble = 1'b1;
          end else if (id_valid && ex_ld_reg && (rs1_ex_match || rs2_ex_match)) begin
            lu_hazard  = 1'b1;
            state_next = LU_STALL;
          end
        end
        LU_STALL: begin
          // The bubble sits in EX now, so no load-use can exist this cycle.
          state_next = RUN;
          if (branch_flush) flush_bubble = 1'b1;
        end
        default: state_next = RUN;
      endcase
    end
  end

  assign bubble      = lu_hazard | flush_bubble;
  assign take_id     = id_valid & ~bubble;
  assign pc_stall    = freeze | lu_hazard;
  assign ifid_stall  = freeze | lu_hazard;
  assign idex_bubble = bubble;
  assign pipe_freeze = freeze;

  // State, scoreboard advance and forward-select capture; all hold on freeze.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= RUN;
      quiet_reg   <= 1'b1;
      ex_rd_reg   <= '0;
      ex_wr_reg   <= 1'b0;
      ex_ld_reg   <= 1'b0;
      mem_rd_reg  <= '0;
      mem_wr_reg  <= 1'b0;
      rs1_exe_reg <= 1'b0;
      rs1_mem_reg <= 1'b0;
      rs2_exe_reg <= 1'b0;
      rs2_mem_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      quiet_reg <= 1'b0;
      if (!freeze) begin
        mem_rd_reg  <= ex_rd_reg;
        mem_wr_reg  <= ex_wr_reg;
        ex_rd_reg   <= take_id ? id_rd_addr   : '0;
        ex_wr_reg   <= take_id & id_reg_write;
        ex_ld_reg   <= take_id & id_mem_read;
        rs1_exe_reg <= take_id & rs1_ex_match;
        rs1_mem_reg <= take_id & rs1_mem_match;
        rs2_exe_reg <= take_id & rs2_ex_match;
        rs2_mem_reg <= take_id & rs2_mem_match;
      end
    end
  end

  assign rs1_exe_hazard = rs1_exe_reg;
  assign rs1_mem_hazard = rs1_mem_reg;
  assign rs2_exe_hazard = rs2_exe_reg;
  assign rs2_mem_hazard = rs2_mem_reg;

`ifdef HAZARD_PERF_EN
  logic [PERF_CNT_W-1:0] cnt_lu_reg, cnt_mem_reg;
  localparam logic [PERF_CNT_W-1:0] CNT_ONE = {{(PERF_CNT_W-1){1'b0}}, 1'b1};

  // Saturating counters of load-use bubbles and data-memory wait cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_lu_reg  <= '0;
      cnt_mem_reg <= '0;
    end else begin
      if (lu_hazard && (cnt_lu_reg != '1))  cnt_lu_reg  <= cnt_lu_reg + CNT_ONE;
      if (freeze    && (cnt_mem_reg != '1)) cnt_mem_reg <= cnt_mem_reg + CNT_ONE;
    end
  end

  assign stall_cnt_lu  = cnt_lu_reg;
  assign stall_cnt_mem = cnt_mem_reg;
`else
  assign stall_cnt_lu  = '0;
  assign stall_cnt_mem = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: an instruction-level model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_hazard_forward_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;
  logic        branch_flush, dmem_busy;
  logic        rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard;
  logic        pc_stall, ifid_stall, idex_bubble, pipe_freeze;
  logic [31:0] stall_cnt_lu, stall_cnt_mem;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .branch_flush(branch_flush), .dmem_busy(dmem_busy),
    .rs1_exe_hazard(rs1_exe_hazard), .rs1_mem_hazard(rs1_mem_hazard),
    .rs2_exe_hazard(rs2_exe_hazard), .rs2_mem_hazard(rs2_mem_hazard),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_bubble(idex_bubble),
    .pipe_freeze(pipe_freeze), .stall_cnt_lu(stall_cnt_lu), .stall_cnt_mem(stall_cnt_mem)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level model ----------------
  typedef struct packed {logic [4:0] rd; logic wr; logic ld;} inst_t;
  inst_t       m_ex, m_mem;
  bit          m_quiet;
  logic        m_f1e, m_f1m, m_f2e, m_f2m;
  logic [31:0] m_clu, m_cmem;

  function automatic bit reads(input logic used, input logic [4:0] a, input inst_t e);
    return used && e.wr && (e.rd != 5'd0) && (a == e.rd);
  endfunction

  // What the pipeline must do this cycle: {freeze, load-use, branch kill}
  function automatic logic [2:0] decide();
    bit on, fz, lu, fl;
    on = rst_n && !m_quiet;
    fz = on && dmem_busy;
    fl = on && !dmem_busy && branch_flush;
    lu = on && !dmem_busy && !branch_flush && id_valid && m_ex.ld &&
         (reads(id_rs1_used, id_rs1_addr, m_ex) || reads(id_rs2_used, id_rs2_addr, m_ex));
    return {fz, lu, fl};
  endfunction

  always @(posedge clk) begin
    logic [2:0] d;
    bit enter;
    d = decide();
    if (!rst_n) begin
      m_ex = '0; m_mem = '0; m_quiet = 1;
      {m_f1e, m_f1m, m_f2e, m_f2m} = 4'b0;
      m_clu = 0; m_cmem = 0;
    end else begin
      m_quiet = 0;
      if (d[2]) m_cmem = (m_cmem == 32'hFFFF_FFFF) ? m_cmem : m_cmem + 1;
      if (d[1]) m_clu  = (m_clu  == 32'hFFFF_FFFF) ? m_clu  : m_clu  + 1;
      if (!d[2]) begin
        enter = id_valid && !d[1] && !d[0];
        m_f1e = enter && reads(id_rs1_used, id_rs1_addr, m_ex);
        m_f1m = enter && reads(id_rs1_used, id_rs1_addr, m_mem);
        m_f2e = enter && reads(id_rs2_used, id_rs2_addr, m_ex);
        m_f2m = enter && reads(id_rs2_used, id_rs2_addr, m_mem);
        m_mem = m_ex;
        m_ex  = enter ? inst_t'{rd: id_rd_addr, wr: id_reg_write, ld: id_mem_read} : '0;
      end
    end
  end

  // Per-cycle compare against the model (mid-cycle, inputs settled).
  always @(negedge clk) begin
    logic [2:0] d;
    d = decide();
    chk("pipe_freeze", {31'b0, pipe_freeze}, {31'b0, d[2]});
    chk("pc_stall",    {31'b0, pc_stall},    {31'b0, d[2] | d[1]});
    chk("ifid_stall",  {31'b0, ifid_stall},  {31'b0, d[2] | d[1]});
    chk("idex_bubble", {31'b0, idex_bubble}, {31'b0, d[1] | d[0]});
    chk("fwd_selects", {28'b0, rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard},
                       {28'b0, m_f1e, m_f1m, m_f2e, m_f2m});
`ifdef HAZARD_PERF_EN
    chk("stall_cnt_lu",  stall_cnt_lu,  m_clu);
    chk("stall_cnt_mem", stall_cnt_mem, m_cmem);
`else
    chk("stall_cnt_lu",  stall_cnt_lu,  32'd0);
    chk("stall_cnt_mem", stall_cnt_mem, 32'd0);
`endif
  end

  // ---------------- directed stimulus ----------------
  logic [3:0] snap;   // {freeze, pc_stall, ifid_stall, bubble} seen mid-cycle

  task automatic ins(input logic [4:0] rd, input logic wr, input logic ld,
                     input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
    id_valid = 1; id_rd_addr = rd; id_reg_write = wr; id_mem_read = ld;
    id_rs1_addr = r1; id_rs1_used = u1; id_rs2_addr = r2; id_rs2_used = u2;
  endtask

  task automatic nop();
    ins(5'd0, 0, 0, 5'd0, 0, 5'd0, 0);
    id_valid = 0;
  endtask

  // One clock: sample the combinational outputs mid-cycle, return just after the edge.
  task automatic step();
    @(negedge clk);
    snap = {pipe_freeze, pc_stall, ifid_stall, idex_bubble};
    $display("[TB] t=%0t id_rd=%0d rs1=%0d rs2=%0d busy=%0b flush=%0b ctl=%4b", $time,
             id_rd_addr, id_rs1_addr, id_rs2_addr, dmem_busy, branch_flush, snap);
    @(posedge clk); #1;
  endtask

  function automatic logic [3:0] fwd();
    return {rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard};
  endfunction

  logic [31:0] lu0, mem0;

  initial begin
    rst_n = 0; branch_flush = 0; dmem_busy = 0; nop();
    step(); step();
    chk("reset_ctl", {28'b0, snap}, 32'd0);
    chk("reset_fwd", {28'b0, fwd()}, 32'd0);
    rst_n = 1; dmem_busy = 1; branch_flush = 1;     // quiet cycle after reset
    step();
    chk("post_reset_ctl", {28'b0, snap}, 32'd0);
    dmem_busy = 0; branch_flush = 0;
    step();

    // add x5,x1,x2 ; add x6,x5,x1 -> EX forward on rs1
    ins(5, 1, 0, 1, 1, 2, 1); step();
    ins(6, 1, 0, 5, 1, 1, 1); step();
    chk("exe_fwd_sel", {28'b0, fwd()}, 32'b1000);
    chk("exe_fwd_nostall", {28'b0, snap}, 32'd0);
    nop(); step(); step();

    // add x5 ; nop ; sub x7,x2,x5 -> MEM forward on rs2
    ins(5, 1, 0, 1, 1, 2, 1); step();
    nop(); step();
    ins(7, 1, 0, 2, 1, 5, 1); step();
    chk("mem_fwd_sel", {28'b0, fwd()}, 32'b0001);
    nop(); step(); step();

    // add x5 ; add x5 ; add x6,x5,x5 -> both selects set on each operand
    ins(5, 1, 0, 1, 1, 2, 1); step(); step();
    ins(6, 1, 0, 5, 1, 5, 1); step();
    chk("both_fwd_sel", {28'b0, fwd()}, 32'b1111);
    nop(); step(); step();

    // lw x5 ; add x6,x5,x5 -> one bubble, then MEM forward on both
    lu0 = stall_cnt_lu;
    ins(5, 1, 1, 1, 1, 0, 0); step();
    ins(6, 1, 0, 5, 1, 5, 1); step();
    chk("lu_ctl", {28'b0, snap}, 32'b0111);
    chk("lu_bubble_fwd", {28'b0, fwd()}, 32'd0);
    step();
    chk("lu_after_ctl", {28'b0, snap}, 32'd0);
    chk("lu_after_fwd", {28'b0, fwd()}, 32'b0101);
`ifdef HAZARD_PERF_EN
    chk("lu_cnt_delta", stall_cnt_lu - lu0, 32'd1);
`endif
    nop(); step(); step();

    // add x0,x1,x2 ; add x3,x0,x0 -> x0 never forwards
    ins(0, 1, 0, 1, 1, 2, 1); step();
    ins(3, 1, 0, 0, 1, 0, 1); step();
    chk("x0_fwd", {28'b0, fwd()}, 32'd0);
    chk("x0_ctl", {28'b0, snap}, 32'd0);
    nop(); step(); step();

    // lw x5 ; use with dmem_busy for 3 cycles -> freeze x3, then the bubble
    lu0 = stall_cnt_lu; mem0 = stall_cnt_mem;
    ins(5, 1, 1, 1, 1, 0, 0); step();
    ins(6, 1, 0, 5, 1, 2, 1); dmem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("freeze_ctl", {28'b0, snap}, 32'b1110);
      chk("freeze_fwd_hold", {28'b0, fwd()}, 32'd0);
    end
    dmem_busy = 0; step();
    chk("freeze_then_lu", {28'b0, snap}, 32'b0111);
    step();
    chk("freeze_lu_fwd", {28'b0, fwd()}, 32'b0100);
`ifdef HAZARD_PERF_EN
    chk("mem_cnt_delta", stall_cnt_mem - mem0, 32'd3);
    chk("lu_cnt_delta2", stall_cnt_lu - lu0, 32'd1);
`endif
    nop(); step(); step();

    // branch flush suppresses the load-use check and kills the ID instruction
    ins(5, 1, 1, 1, 1, 0, 0); step();
    ins(6, 1, 0, 5, 1, 0, 0); branch_flush = 1; step();
    chk("flush_ctl", {28'b0, snap}, 32'b0001);
    chk("flush_fwd", {28'b0, fwd()}, 32'd0);
    branch_flush = 0; nop(); step(); step();

    // reset in LU_STALL -> quiet that cycle and the next
    ins(5, 1, 1, 1, 1, 0, 0); step();
    ins(6, 1, 0, 5, 1, 0, 0); step();
    chk("pre_reset_lu", {28'b0, snap}, 32'b0111);
    rst_n = 0; dmem_busy = 1; step();
    chk("reset_in_lu_ctl", {28'b0, snap}, 32'd0);
    rst_n = 1; step();
    chk("reset_in_lu_next", {28'b0, snap}, 32'd0);
    chk("reset_in_lu_fwd", {28'b0, fwd()}, 32'd0);
    dmem_busy = 0; nop(); step();
    chk("resume_run", {28'b0, snap}, 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
